// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage between the PC register and decode.
// One outstanding req/gnt/rvalid read, DEPTH-entry in-order buffer.
module inst_fetch_unit #(
  parameter int PC_W   = 12,
  parameter int INST_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_flush,
  output logic              o_pc_advance,
  output logic              o_mem_req,
  output logic [PC_W-1:0]   o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [INST_W-1:0] i_mem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_inst_pc,
  input  logic              i_dec_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_t           state;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ;
  logic             space;
  logic             full;
  logic             push;
  logic             pop;
  entry_t           head;

  // A request in WAIT already owns a slot, so count it as occupied.
  assign occ   = count + CNT_W'(state == WAIT);
  assign space = occ < CNT_W'(DEPTH);
  assign full  = count == CNT_W'(DEPTH);

  assign push = (state == WAIT) && i_mem_rvalid
             && !i_flush;
  assign pop  = o_inst_valid && i_dec_ready
             && !i_flush;

  assign o_pc_advance = o_mem_req && i_mem_gnt
                     && !i_flush;

  assign head         = fifo_q[rd_ptr];
  assign o_inst_valid = count != '0;
  assign o_inst       = o_inst_valid ? head.inst : '0;
  assign o_inst_pc    = o_inst_valid ? head.pc : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (space && !i_flush) begin
            state      <= REQ;
            o_mem_req  <= 1'b1;
            o_mem_addr <= i_pc;
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            state     <= i_flush ? DROP : WAIT;
          end else if (i_flush) begin
            o_mem_req <= 1'b0;
            state     <= IDLE;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
          end else if (i_flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is gated by o_inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: o_mem_addr, inst: i_mem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for inst_fetch_unit.
// Memory and PC register are driven by hand, cycle by cycle.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] i_pc;
  logic        i_flush;
  logic        o_pc_advance;
  logic        o_mem_req;
  logic [11:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [15:0] i_mem_rdata;
  logic        o_inst_valid;
  logic [15:0] o_inst;
  logic [11:0] o_inst_pc;
  logic        i_dec_ready;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit #(
    .PC_W  (12),
    .INST_W(16),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_pc        (i_pc),
    .i_flush     (i_flush),
    .o_pc_advance(o_pc_advance),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_gnt   (i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata (i_mem_rdata),
    .o_inst_valid(o_inst_valid),
    .o_inst      (o_inst),
    .o_inst_pc   (o_inst_pc),
    .i_dec_ready (i_dec_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(o_mem_req), 32'h0);
    chk({tag, "_addr"}, 32'(o_mem_addr), 32'h0);
    chk({tag, "_adv"}, 32'(o_pc_advance), 32'h0);
    chk({tag, "_vld"}, 32'(o_inst_valid), 32'h0);
    chk({tag, "_inst"}, 32'(o_inst), 32'h0);
    chk({tag, "_ipc"}, 32'(o_inst_pc), 32'h0);
  endtask

  task automatic chk_head(input string tag,
                          input logic [15:0] inst,
                          input logic [11:0] pc);
    chk({tag, "_vld"}, 32'(o_inst_valid), 32'h1);
    chk({tag, "_inst"}, 32'(o_inst), 32'(inst));
    chk({tag, "_ipc"}, 32'(o_inst_pc), 32'(pc));
  endtask

  initial begin
    reset        = 1'b0;
    i_pc         = 12'h010;
    i_flush      = 1'b0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 16'h0;
    i_dec_ready  = 1'b0;
    tick();
    tick();
    chk_zero("rst");

    // 1: basic fetch, gnt in first REQ cycle
    reset = 1'b1;
    tick();
    chk("t1_req", 32'(o_mem_req), 32'h1);
    chk("t1_addr", 32'(o_mem_addr), 32'h010);
    i_mem_gnt = 1'b1;
    #1;
    chk("t1_adv", 32'(o_pc_advance), 32'h1);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'hA5A5;
    i_pc         = 12'h011;
    #1;
    chk("t1_adv_off", 32'(o_pc_advance), 32'h0);
    chk("t1_req_off", 32'(o_mem_req), 32'h0);
    chk("t1_vld_early", 32'(o_inst_valid), 32'h0);
    tick();
    i_mem_rvalid = 1'b0;
    chk_head("t1_head", 16'hA5A5, 12'h010);

    // 2: decode stalled, buffer fills, fetch stops
    tick();
    chk("t2_req", 32'(o_mem_req), 32'h1);
    chk("t2_addr", 32'(o_mem_addr), 32'h011);
    i_mem_gnt = 1'b1;
    #1;
    chk("t2_adv", 32'(o_pc_advance), 32'h1);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'h1234;
    i_pc         = 12'h012;
    tick();
    i_mem_rvalid = 1'b0;
    chk_head("t2_hold", 16'hA5A5, 12'h010);
    tick();
    chk("t2_noreq1", 32'(o_mem_req), 32'h0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'hFFFF;
    tick();
    i_mem_rvalid = 1'b0;
    chk("t2_noreq2", 32'(o_mem_req), 32'h0);
    chk_head("t2_stray", 16'hA5A5, 12'h010);
    i_dec_ready = 1'b1;
    tick();
    chk_head("t2_pop1", 16'h1234, 12'h011);
    chk("t2_noreq3", 32'(o_mem_req), 32'h0);
    tick();
    chk("t2_empty", 32'(o_inst_valid), 32'h0);
    chk("t2_resume", 32'(o_mem_req), 32'h1);
    chk("t2_raddr", 32'(o_mem_addr), 32'h012);

    // 3: gnt delayed three cycles, address held
    i_dec_ready = 1'b0;
    i_pc        = 12'h050;
    #1;
    chk("t3_adv0", 32'(o_pc_advance), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_req", 32'(o_mem_req), 32'h1);
      chk("t3_addr", 32'(o_mem_addr), 32'h012);
      chk("t3_adv", 32'(o_pc_advance), 32'h0);
    end
    i_mem_gnt = 1'b1;
    #1;
    chk("t3_adv_gnt", 32'(o_pc_advance), 32'h1);
    tick();
    i_mem_gnt = 1'b0;
    i_pc      = 12'h013;
    #1;
    chk("t3_adv_off", 32'(o_pc_advance), 32'h0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'h3333;
    tick();
    i_mem_rvalid = 1'b0;
    chk_head("t3_head", 16'h3333, 12'h012);

    // 4: flush in WAIT with one entry buffered
    tick();
    chk("t4_req", 32'(o_mem_req), 32'h1);
    chk("t4_addr", 32'(o_mem_addr), 32'h013);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_flush   = 1'b1;
    i_pc      = 12'h200;
    #1;
    chk("t4_vld_fcyc", 32'(o_inst_valid), 32'h1);
    tick();
    i_flush = 1'b0;
    chk("t4_vld_gone", 32'(o_inst_valid), 32'h0);
    chk("t4_noreq", 32'(o_mem_req), 32'h0);
    tick();
    chk("t4_drop_wait", 32'(o_mem_req), 32'h0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'hDEAD;
    tick();
    i_mem_rvalid = 1'b0;
    chk("t4_discard", 32'(o_inst_valid), 32'h0);
    tick();
    chk("t4_req_new", 32'(o_mem_req), 32'h1);
    chk("t4_addr_new", 32'(o_mem_addr), 32'h200);
    chk("t4_vld", 32'(o_inst_valid), 32'h0);

    // 5: flush coincident with gnt
    i_mem_gnt = 1'b1;
    i_flush   = 1'b1;
    i_pc      = 12'h300;
    #1;
    chk("t5_adv", 32'(o_pc_advance), 32'h0);
    tick();
    i_mem_gnt = 1'b0;
    i_flush   = 1'b0;
    chk("t5_noreq", 32'(o_mem_req), 32'h0);
    tick();
    chk("t5_drop", 32'(o_mem_req), 32'h0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'hBEEF;
    tick();
    i_mem_rvalid = 1'b0;
    chk("t5_nopush", 32'(o_inst_valid), 32'h0);
    tick();
    chk("t5_req", 32'(o_mem_req), 32'h1);
    chk("t5_addr", 32'(o_mem_addr), 32'h300);

    // 6: reset asserted while WAIT holds the last free slot
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'h0300;
    i_pc         = 12'h301;
    tick();
    i_mem_rvalid = 1'b0;
    chk_head("t6_head", 16'h0300, 12'h300);
    tick();
    chk("t6_addr", 32'(o_mem_addr), 32'h301);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    reset     = 1'b0;
    #1;
    chk_zero("t6_async");
    tick();
    chk_zero("t6_held");
    reset = 1'b1;
    i_pc  = 12'h400;
    tick();
    chk("t6_req", 32'(o_mem_req), 32'h1);
    chk("t6_raddr", 32'(o_mem_addr), 32'h400);
    chk("t6_vld", 32'(o_inst_valid), 32'h0);
    i_mem_gnt = 1'b1;
    #1;
    chk("t6_adv", 32'(o_pc_advance), 32'h1);
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 16'h4444;
    tick();
    i_mem_rvalid = 1'b0;
    chk_head("t6_fetch", 16'h4444, 12'h400);
    i_dec_ready = 1'b1;
    tick();
    chk("t6_popped", 32'(o_inst_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
